// File: rtl/lv2_mem_req_ctrl.sv
// L2 memory request controller: one request at a time, write-back and/or fill over a shared tristate bus.
// Latency from accept: read-only or write-only 3 cycles, writeback+fill 5 cycles; per-access timeout of TIMEOUT_CYC.
// Backpressure: req_ready high only in IDLE; resp_valid is a single-cycle pulse. Optional LV2_MEM_UNINIT_CHECK_EN flags fills that return the uninitialised pattern.

`ifndef DATA_WID_LV2
`define DATA_WID_LV2 32
`endif
`ifndef ADDR_WID_LV2
`define ADDR_WID_LV2 32
`endif

module lv2_mem_req_ctrl #(
    parameter int DATA_WID    = `DATA_WID_LV2,
    parameter int ADDR_WID    = `ADDR_WID_LV2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic [ADDR_WID-1:0] req_addr,
    input  logic [ADDR_WID-1:0] req_wb_addr,
    input  logic [DATA_WID-1:0] req_wdata,
    output logic                resp_valid,
    output logic [DATA_WID-1:0] resp_rdata,
    output logic                resp_err,
    inout  wire  [DATA_WID-1:0] data_bus_lv2_mem,
    output logic [ADDR_WID-1:0] addr_bus_lv2_mem,
    output logic                mem_rd,
    output logic                mem_wr,
    input  logic                mem_wr_done,
    input  logic                data_in_bus_lv2_mem
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
`ifdef LV2_MEM_UNINIT_CHECK_EN
    localparam logic [DATA_WID-1:0] UNINIT_PAT = DATA_WID'(32'h2333_2333);
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  rd_pend_q;
    logic [ADDR_WID-1:0]   rd_addr_q;
    logic [ADDR_WID-1:0]   wb_addr_q;
    logic [DATA_WID-1:0]   wdata_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WID-1:0]   rdata_q;
    logic                  err_q;

    logic                  bus_oe;
    logic                  cnt_clr;
    logic                  cnt_inc;
    logic                  load_resp;
    logic                  err_d;
    logic [DATA_WID-1:0]   rdata_d;

    assign data_bus_lv2_mem = bus_oe ? wdata_q : {DATA_WID{1'bz}};
    assign resp_rdata       = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_err         = 1'b0;
        mem_rd           = 1'b0;
        mem_wr           = 1'b0;
        bus_oe           = 1'b0;
        addr_bus_lv2_mem = '0;
        cnt_clr          = 1'b0;
        cnt_inc          = 1'b0;
        load_resp        = 1'b0;
        err_d            = 1'b0;
        rdata_d          = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_wr) begin
                        state_d = WB_REQ;
                    end else if (req_rd) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d   = RESP;
                        load_resp = 1'b1;
                        err_d     = 1'b1;
                    end
                end
            end
            WB_REQ: begin
                mem_wr           = 1'b1;
                bus_oe           = 1'b1;
                addr_bus_lv2_mem = wb_addr_q;
                cnt_clr          = 1'b1;
                state_d          = WB_WAIT;
            end
            WB_WAIT: begin
                addr_bus_lv2_mem = wb_addr_q;
                // An ack on the final counted cycle still beats the timeout.
                if (mem_wr_done) begin
                    if (rd_pend_q) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d   = RESP;
                        load_resp = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    load_resp = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RD_REQ: begin
                mem_rd           = 1'b1;
                addr_bus_lv2_mem = rd_addr_q;
                cnt_clr          = 1'b1;
                state_d          = RD_WAIT;
            end
            RD_WAIT: begin
                addr_bus_lv2_mem = rd_addr_q;
                if (data_in_bus_lv2_mem) begin
                    state_d   = RESP;
                    load_resp = 1'b1;
                    rdata_d   = data_bus_lv2_mem;
`ifdef LV2_MEM_UNINIT_CHECK_EN
                    err_d     = (data_bus_lv2_mem == UNINIT_PAT);
`else
                    err_d     = 1'b0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RESP;
                    load_resp = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            wb_addr_q <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                rd_pend_q <= req_rd;
                rd_addr_q <= req_addr;
                wb_addr_q <= req_wb_addr;
                wdata_q   <= req_wdata;
            end
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Response fields only change on entry to RESP so resp_rdata holds between responses.
            if (load_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

endmodule

// File: tb/tb_lv2_mem_req_ctrl.sv
// Directed bench for lv2_mem_req_ctrl with a small one-cycle-ack memory model.
// Uninitialised-pattern error expectation follows LV2_MEM_UNINIT_CHECK_EN.

module tb_lv2_mem_req_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 8;
    localparam logic [31:0] UNINIT = 32'h2333_2333;
`ifdef LV2_MEM_UNINIT_CHECK_EN
    localparam logic UNINIT_ERR = 1'b1;
`else
    localparam logic UNINIT_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_rd;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_wb_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    wire  [DW-1:0] data_bus_lv2_mem;
    logic [AW-1:0] addr_bus_lv2_mem;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_wr_done;
    logic          data_in_bus_lv2_mem;

    logic          no_ack;
    logic          mdl_done;
    logic          mdl_din;
    logic          mdl_drv;
    logic [DW-1:0] mdl_data;
    logic          man_done;
    logic          man_din;
    logic          man_drv;
    logic [DW-1:0] man_data;
    logic [DW-1:0] mem [logic [AW-1:0]];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign data_bus_lv2_mem    = mdl_drv ? mdl_data : (man_drv ? man_data : {DW{1'bz}});
    assign mem_wr_done         = mdl_done | man_done;
    assign data_in_bus_lv2_mem = mdl_din | man_din;

    lv2_mem_req_ctrl #(
        .DATA_WID(DW),
        .ADDR_WID(AW),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_rd(req_rd),
        .req_wr(req_wr),
        .req_addr(req_addr),
        .req_wb_addr(req_wb_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .data_bus_lv2_mem(data_bus_lv2_mem),
        .addr_bus_lv2_mem(addr_bus_lv2_mem),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_wr_done(mem_wr_done),
        .data_in_bus_lv2_mem(data_in_bus_lv2_mem)
    );

    // Memory acks one cycle after each strobe; unwritten locations read the fill pattern.
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        mdl_din  <= 1'b0;
        mdl_drv  <= 1'b0;
        if (!no_ack && !rst) begin
            if (mem_wr) begin
                mem[addr_bus_lv2_mem] = data_bus_lv2_mem;
                mdl_done <= 1'b1;
            end
            if (mem_rd) begin
                mdl_data <= mem.exists(addr_bus_lv2_mem) ? mem[addr_bus_lv2_mem] : UNINIT;
                mdl_drv  <= 1'b1;
                mdl_din  <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 1 after acceptance.
    task automatic issue(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        req_rd      = rd;
        req_wr      = wr;
        req_addr    = a;
        req_wb_addr = wa;
        req_wdata   = wd;
        req_valid   = 1'b1;
        check("accept_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid   = 1'b0;
        req_rd      = 1'b1;
        req_wr      = 1'b1;
        req_addr    = '1;
        req_wb_addr = '1;
        req_wdata   = '1;
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wb_addr = '0; req_wdata = '0;
        no_ack = 1'b0;
        man_done = 1'b0; man_din = 1'b0; man_drv = 1'b0; man_data = '0;
        mdl_data = '0;
        mem[32'h40] = 32'hDEAD_BEEF;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_rdata", 64'(resp_rdata), 64'd0);
        check("rst_strobes", 64'({mem_rd, mem_wr}), 64'd0);
        check("rst_addr", 64'(addr_bus_lv2_mem), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read-only fill
        issue(1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
        check("rd_mem_rd_c1", 64'(mem_rd), 64'd1);
        check("rd_mem_wr_c1", 64'(mem_wr), 64'd0);
        check("rd_addr_c1", 64'(addr_bus_lv2_mem), 64'h40);
        @(negedge clk);
        check("rd_mem_rd_c2", 64'(mem_rd), 64'd0);
        check("rd_resp_c2", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("rd_resp_c3", 64'(resp_valid), 64'd1);
        check("rd_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
        check("rd_err", 64'(resp_err), 64'd0);
        check("rd_ready_resp", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("rd_resp_c4", 64'(resp_valid), 64'd0);
        check("rd_rdata_hold", 64'(resp_rdata), 64'hDEAD_BEEF);

        // Write-only
        issue(1'b0, 1'b1, 32'h0, 32'h80, 32'h1234_5678);
        check("wr_mem_wr_c1", 64'(mem_wr), 64'd1);
        check("wr_bus_c1", 64'(data_bus_lv2_mem), 64'h1234_5678);
        check("wr_addr_c1", 64'(addr_bus_lv2_mem), 64'h80);
        check("wr_mem_rd_c1", 64'(mem_rd), 64'd0);
        @(negedge clk);
        check("wr_mem_wr_c2", 64'(mem_wr), 64'd0);
        @(negedge clk);
        check("wr_resp_c3", 64'(resp_valid), 64'd1);
        check("wr_err", 64'(resp_err), 64'd0);
        check("wr_rdata_zero", 64'(resp_rdata), 64'd0);
        @(negedge clk);
        issue(1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("wr_readback_valid", 64'(resp_valid), 64'd1);
        check("wr_readback_data", 64'(resp_rdata), 64'h1234_5678);

        // Writeback then fill, same address
        @(negedge clk);
        issue(1'b1, 1'b1, 32'h10, 32'h10, 32'hA5A5_A5A5);
        check("wbf_mem_wr_c1", 64'({mem_wr, mem_rd}), 64'b10);
        check("wbf_ready_c1", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("wbf_strobes_c2", 64'({mem_wr, mem_rd}), 64'b00);
        check("wbf_ready_c2", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("wbf_mem_rd_c3", 64'({mem_wr, mem_rd}), 64'b01);
        check("wbf_addr_c3", 64'(addr_bus_lv2_mem), 64'h10);
        @(negedge clk);
        check("wbf_resp_c4", 64'(resp_valid), 64'd0);
        check("wbf_ready_c4", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("wbf_resp_c5", 64'(resp_valid), 64'd1);
        check("wbf_rdata", 64'(resp_rdata), 64'hA5A5_A5A5);
        check("wbf_err", 64'(resp_err), 64'd0);

        // Illegal request
        @(negedge clk);
        issue(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        check("ill_resp_c1", 64'(resp_valid), 64'd1);
        check("ill_err", 64'(resp_err), 64'd1);
        check("ill_rdata", 64'(resp_rdata), 64'd0);
        check("ill_no_strobe", 64'({mem_wr, mem_rd}), 64'd0);

        // Stray acks while idle
        @(negedge clk);
        man_drv = 1'b1; man_data = 32'hFFFF_0000; man_din = 1'b1; man_done = 1'b1;
        @(negedge clk);
        man_drv = 1'b0; man_din = 1'b0; man_done = 1'b0;
        check("stray_ready", 64'(req_ready), 64'd1);
        check("stray_resp", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("stray_resp_next", 64'(resp_valid), 64'd0);
        check("stray_rdata", 64'(resp_rdata), 64'd0);

        // Read timeout
        no_ack = 1'b1;
        issue(1'b1, 1'b0, 32'h44, 32'h0, 32'h0);
        seen = 1'b0;
        for (int k = 2; k <= T + 1; k++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("to_early_resp", 64'(seen), 64'd0);
        @(negedge clk);
        check("to_resp", 64'(resp_valid), 64'd1);
        check("to_err", 64'(resp_err), 64'd1);
        check("to_rdata", 64'(resp_rdata), 64'd0);
        @(negedge clk);
        no_ack = 1'b0;
        issue(1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("to_after_resp", 64'(resp_valid), 64'd1);
        check("to_after_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);

        // Ack on the last timeout cycle wins
        @(negedge clk);
        no_ack = 1'b1;
        issue(1'b1, 1'b0, 32'h48, 32'h0, 32'h0);
        for (int k = 2; k <= T; k++) begin
            @(negedge clk);
        end
        @(negedge clk);
        man_drv = 1'b1; man_din = 1'b1; man_data = 32'hCAFE_F00D;
        @(negedge clk);
        man_drv = 1'b0; man_din = 1'b0;
        check("late_ack_resp", 64'(resp_valid), 64'd1);
        check("late_ack_err", 64'(resp_err), 64'd0);
        check("late_ack_rdata", 64'(resp_rdata), 64'hCAFE_F00D);

        // Reset during WB_WAIT
        @(negedge clk);
        issue(1'b0, 1'b1, 32'h0, 32'h90, 32'h1111_2222);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        man_done = 1'b1; man_drv = 1'b1; man_data = 32'h5A5A_0000;
        #1;
        check("rstmid_strobes", 64'({mem_wr, mem_rd}), 64'd0);
        check("rstmid_ready", 64'(req_ready), 64'd1);
        check("rstmid_resp", 64'(resp_valid), 64'd0);
        check("rstmid_bus_released", 64'(data_bus_lv2_mem), 64'h5A5A_0000);
        @(negedge clk);
        man_done = 1'b0; man_drv = 1'b0;
        check("rstmid_ack_ignored", 64'(resp_valid), 64'd0);
        check("rstmid_ready_after", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("rstmid_resp_after", 64'(resp_valid), 64'd0);
        no_ack = 1'b0;

        // Uninitialised location
        issue(1'b1, 1'b0, 32'h300, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("uninit_resp", 64'(resp_valid), 64'd1);
        check("uninit_rdata", 64'(resp_rdata), 64'(UNINIT));
        check("uninit_err", 64'(resp_err), 64'(UNINIT_ERR));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lv2_mem_req_ctrl.md
Name: lv2_mem_req_ctrl

Overview:
- Initiator side of the LV2-to-memory bus: the L2 cache's memory request controller.
- Accepts one request at a time from L2 miss/eviction logic.
- Drives mem_rd/mem_wr pulses, address, and the shared tristate data bus; waits for data_in_bus_lv2_mem or mem_wr_done.
- Returns a single-cycle response; supports write-only, read-only (fill) and writeback-then-fill, with a per-access timeout.

Parameters:
DATA_WID, `DATA_WID_LV2, data bus width
ADDR_WID, `ADDR_WID_LV2, address width
TIMEOUT_CYC, 64, max cycles waited for mem_wr_done/data_in_bus_lv2_mem per access (>=2)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
req_rd  input  1  perform fill read at req_addr
req_wr  input  1  perform write of req_wdata to req_wb_addr
req_addr  input  ADDR_WID  fill address
req_wb_addr  input  ADDR_WID  write/victim address
req_wdata  input  DATA_WID  write/victim data
resp_valid  output  1  one-cycle response pulse, no backpressure
resp_rdata  output  DATA_WID  fill data (0 when no read or on error)
resp_err  output  1  timeout or illegal request
data_bus_lv2_mem  inout  DATA_WID  shared bus; driven only in WB_REQ, else 'z
addr_bus_lv2_mem  output  ADDR_WID  access address
mem_rd  output  1  one-cycle read strobe
mem_wr  output  1  one-cycle write strobe
mem_wr_done  input  1  write acknowledge
data_in_bus_lv2_mem  input  1  read data valid on data_bus_lv2_mem

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_rd=0, mem_wr=0, addr_bus_lv2_mem=0, bus released ('z), timeout counter=0. Reset mid-transaction drops it with no response; acks arriving after reset are ignored.
- Request latching: on acceptance, the request fields are latched; inputs are don't-care afterwards.
- States: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP.
- IDLE transitions on accept:
  - req_wr=1 -> WB_REQ.
  - req_rd=1 only -> RD_REQ.
  - Neither set -> RESP with resp_err=1 (illegal).
- WB_REQ (1 cycle): mem_wr=1, addr_bus=wb_addr, bus driven with wdata -> WB_WAIT.
- WB_WAIT: bus 'z, strobes low.
  - On mem_wr_done: -> RD_REQ if the read is pending, else RESP.
- RD_REQ (1 cycle): mem_rd=1, addr_bus=req_addr, bus 'z -> RD_WAIT.
- RD_WAIT: on data_in_bus_lv2_mem, capture the bus into resp_rdata -> RESP.
- RESP (1 cycle): resp_valid=1 -> IDLE.
- Strobes are always single-cycle pulses, so the memory is never double-triggered. The controller never drives the bus in a cycle following mem_rd, so there is no bus contention.
- Timing, counted from the acceptance edge:
  - Read-only: resp_valid 3 cycles later.
  - Write-only: resp_valid 3 cycles later.
  - Writeback+fill: resp_valid 5 cycles later, with the write strictly before the read even if the addresses are equal.
- Timeout: the counter clears on entry to each WAIT state and increments each WAIT cycle. When it reaches TIMEOUT_CYC without an ack -> RESP with resp_err=1 and resp_rdata=0; a pending fill is skipped.
- Stray or late mem_wr_done / data_in_bus_lv2_mem outside the matching WAIT state is ignored.
- An ack arriving in the same cycle the counter hits TIMEOUT_CYC counts as success (the ack wins).
- resp_rdata holds its value until the next RESP.

Optional Feature:
LV2_MEM_UNINIT_CHECK_EN:
- Defined: in RD_WAIT, captured data equal to 32'h2333_2333 (the uninitialised-memory fill pattern, zero-extended/truncated to DATA_WID) sets resp_err=1 in RESP; resp_rdata still carries the value.
- Undefined: no pattern check; resp_err only for timeout or illegal request.

Test Plan:
- Read-only:
  - Stimulus: preload mem[0x40]=0xDEAD_BEEF; issue req_rd=1, req_addr=0x40.
  - Response: mem_rd pulses 1 cycle after accept; resp_valid 3 cycles after accept with rdata 0xDEAD_BEEF, err=0.
- Write-only:
  - Stimulus: req_wr=1, wb_addr=0x80, wdata=0x1234_5678.
  - Response: bus shows 0x1234_5678 during the mem_wr cycle; resp_valid 3 cycles after accept, err=0; a later read of 0x80 returns 0x1234_5678.
- Writeback+fill to the same address:
  - Stimulus: wb_addr=req_addr=0x10, wdata=0xA5A5_A5A5.
  - Response: mem_wr precedes mem_rd; resp_rdata=0xA5A5_A5A5 after 5 cycles; req_ready low throughout.
- Timeout:
  - Stimulus: memory stubbed to never ack; issue a read.
  - Response: resp_valid with err=1, rdata=0 exactly TIMEOUT_CYC+2 cycles after accept; a new request is accepted next cycle.
- Reset mid-operation:
  - Stimulus: assert rst in WB_WAIT.
  - Response: next cycle all strobes 0, bus 'z, req_ready=1, no resp_valid; the ensuing mem_wr_done is ignored.
- Uninitialised read:
  - Stimulus: read of never-written 0x300.
  - Response: rdata=0x2333_2333; err=1 only with LV2_MEM_UNINIT_CHECK_EN defined.
